// File: rtl/spi_mem_bridge_if.sv
// Core-side bus of the serial memory bridge: one instruction-fetch port and
// one load/store data port, each a held request with a one-cycle ack.
//   i_req/i_addr           fetch request, held until i_ack
//   i_ack/i_rdata/i_fault  fetch completion
//   d_req/d_ctrl/d_addr/d_wdata  data request (d_ctrl encodes op and size)
//   d_ack/d_rdata/d_fault  data completion
// master = requester (core), slave = bridge.
interface spi_mem_bridge_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        i_fault;
  logic        d_req;
  logic [2:0]  d_ctrl;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_fault;

  modport master (
    output i_req, i_addr, d_req, d_ctrl, d_addr, d_wdata,
    input  i_ack, i_rdata, i_fault, d_ack, d_rdata, d_fault
  );

  modport slave (
    input  i_req, i_addr, d_req, d_ctrl, d_addr, d_wdata,
    output i_ack, i_rdata, i_fault, d_ack, d_rdata, d_fault
  );
endinterface

// File: rtl/spi_mem_bridge.sv
// Arbitrates a fetch port and a load/store port onto one serial memory link
// of LANE_W data lanes. Decodes the IM/DM/GPO/GPI map, sizes and extends
// loads, handles GPO/GPI bytes locally and faults illegal or stalled accesses.
// Ports:
//   clk, rst      single clock, synchronous active-high reset
//   bus           core-side fetch/data request bus (slave modport)
//   mem_cs/we     transaction select and direction toward the PHY
//   mem_size      01 byte, 10 half, 11 word
//   mem_addr      byte address (low 24 bits)
//   mem_dout/din  write/read beat, least-significant lane first
//   mem_beat      PHY moves one beat this cycle
//   gpo/gpi       8 output / 8 input bytes
// LANE_W must be 1, 2, 4 or 8.
module spi_mem_bridge #(
  parameter int unsigned LANE_W   = 4,
  parameter logic [31:0] IM_START = 32'h0000_0000,
  parameter logic [31:0] IM_STOP  = 32'h007F_FFFF,
  parameter logic [31:0] DM_START = 32'h0080_0000,
  parameter logic [31:0] DM_STOP  = 32'h00FF_FFFF,
  parameter logic [31:0] GPO_BASE = 32'h0100_0000,
  parameter logic [31:0] GPI_BASE = 32'h0100_0008,
  parameter bit          IM_WP    = 1'b1,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic              clk,
  input  logic              rst,
  spi_mem_bridge_if.slave   bus,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [1:0]        mem_size,
  output logic [23:0]       mem_addr,
  output logic [LANE_W-1:0] mem_dout,
  input  logic [LANE_W-1:0] mem_din,
  input  logic              mem_beat,
  output logic [63:0]       gpo,
  input  logic [63:0]       gpi
);

  typedef enum logic [1:0] {StIdle, StXfer, StDone} state_e;

  localparam logic [5:0] LANE_B = 6'(LANE_W);

  state_e              r_state;
  logic                r_sel_d;
  logic [2:0]          r_ctrl;
  logic                r_i_ack, r_d_ack, r_fault;
  logic [31:0]         r_rdata;
  logic                r_mem_cs, r_mem_we;
  logic [1:0]          r_mem_size;
  logic [23:0]         r_mem_addr;
  logic [LANE_W-1:0]   r_mem_dout;
  logic [31:0]         r_wdata, r_buf, r_idle;
  logic [5:0]          r_bit, r_nbits;
  logic [63:0]         r_gpo;

  logic        w_sel_d, w_grant, w_we, w_fault, w_misalign;
  logic        w_in_im, w_in_dm, w_in_gpo, w_in_gpi;
  logic [2:0]  w_ctrl;
  logic [1:0]  w_size;
  logic [5:0]  w_nbits, w_bit_nxt;
  logic [31:0] w_addr, w_gpo_off, w_gpi_off, w_buf_nxt;
  logic [7:0]  w_gpi_byte;

  function automatic logic [31:0] f_extend(input logic [2:0] ctrl, input logic [31:0] raw);
    case (ctrl)
      3'b000:  f_extend = {{24{raw[7]}}, raw[7:0]};
      3'b001:  f_extend = {{16{raw[15]}}, raw[15:0]};
      3'b011:  f_extend = {24'b0, raw[7:0]};
      3'b100:  f_extend = {16'b0, raw[15:0]};
      default: f_extend = raw;
    endcase
  endfunction

  // Grant-cycle decode; data port wins when both request.
  always_comb begin
    w_sel_d = bus.d_req;
    w_grant = bus.d_req | bus.i_req;
    w_addr  = w_sel_d ? bus.d_addr : bus.i_addr;
    w_ctrl  = w_sel_d ? bus.d_ctrl : 3'b010;
    w_we    = w_sel_d && (bus.d_ctrl >= 3'd5);
    case (w_ctrl)
      3'b000, 3'b011, 3'b101: begin w_size = 2'b01; w_nbits = 6'd8;  end
      3'b001, 3'b100, 3'b110: begin w_size = 2'b10; w_nbits = 6'd16; end
      default:                begin w_size = 2'b11; w_nbits = 6'd32; end
    endcase
    // Offset compares avoid constant-true bounds when a region starts at 0.
    w_in_im    = (w_addr - IM_START) <= (IM_STOP - IM_START);
    w_in_dm    = (w_addr - DM_START) <= (DM_STOP - DM_START);
    w_gpo_off  = w_addr - GPO_BASE;
    w_gpi_off  = w_addr - GPI_BASE;
    w_in_gpo   = w_gpo_off < 32'd8;
    w_in_gpi   = w_gpi_off < 32'd8;
    w_gpi_byte = 8'(gpi >> {w_gpi_off[2:0], 3'b000});
    w_misalign = ((w_size == 2'b10) && w_addr[0]) || ((w_size == 2'b11) && (w_addr[1:0] != 2'b00));
    w_fault    = !(w_in_im || w_in_dm || w_in_gpo || w_in_gpi) || w_misalign ||
                 (!w_sel_d && !w_in_im) || (w_we && w_in_im && IM_WP) ||
                 ((w_in_gpo || w_in_gpi) && (w_size != 2'b01)) ||
                 (w_in_gpo && !w_we) || (w_in_gpi && w_we);
    // Buffer is cleared at grant, so each beat ORs in at its bit offset.
    w_bit_nxt  = r_bit + LANE_B;
    w_buf_nxt  = r_buf | (32'(mem_din) << r_bit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_sel_d    <= 1'b0;
      r_ctrl     <= 3'b000;
      r_i_ack    <= 1'b0;
      r_d_ack    <= 1'b0;
      r_fault    <= 1'b0;
      r_rdata    <= '0;
      r_mem_cs   <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_size <= 2'b00;
      r_mem_addr <= '0;
      r_mem_dout <= '0;
      r_wdata    <= '0;
      r_buf      <= '0;
      r_idle     <= '0;
      r_bit      <= '0;
      r_nbits    <= '0;
      r_gpo      <= '0;
    end else begin
      r_i_ack <= 1'b0;
      r_d_ack <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_grant) begin
            r_sel_d <= w_sel_d;
            r_ctrl  <= w_ctrl;
            if (w_fault || w_in_gpo || w_in_gpi) begin
              // Resolved locally: ack next cycle, no memory activity.
              r_fault <= w_fault;
              r_rdata <= (!w_fault && w_in_gpi) ? f_extend(w_ctrl, {24'b0, w_gpi_byte}) : '0;
              if (!w_fault && w_in_gpo) begin
                r_gpo[{w_gpo_off[2:0], 3'b000} +: 8] <= bus.d_wdata[7:0];
              end
              r_d_ack <= w_sel_d;
              r_i_ack <= !w_sel_d;
              r_state <= StDone;
            end else begin
              r_mem_cs   <= 1'b1;
              r_mem_we   <= w_we;
              r_mem_size <= w_size;
              r_mem_addr <= w_addr[23:0];
              r_mem_dout <= w_we ? LANE_W'(bus.d_wdata) : '0;
              r_wdata    <= bus.d_wdata;
              r_buf      <= '0;
              r_bit      <= '0;
              r_nbits    <= w_nbits;
              r_idle     <= '0;
              r_state    <= StXfer;
            end
          end
        end
        StXfer: begin
          if (mem_beat) begin
            r_idle <= '0;
            r_buf  <= w_buf_nxt;
            r_bit  <= w_bit_nxt;
            if (w_bit_nxt == r_nbits) begin
              r_mem_cs   <= 1'b0;
              r_mem_we   <= 1'b0;
              r_mem_dout <= '0;
              r_fault    <= 1'b0;
              r_rdata    <= r_mem_we ? '0 : f_extend(r_ctrl, w_buf_nxt);
              r_d_ack    <= r_sel_d;
              r_i_ack    <= !r_sel_d;
              r_state    <= StDone;
            end else if (r_mem_we) begin
              r_mem_dout <= LANE_W'(r_wdata >> w_bit_nxt);
            end
          end else if ((TIMEOUT != 0) && (r_idle == 32'(TIMEOUT - 1))) begin
            // Stalled PHY: abandon the transfer and report a fault.
            r_mem_cs   <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_dout <= '0;
            r_fault    <= 1'b1;
            r_rdata    <= '0;
            r_d_ack    <= r_sel_d;
            r_i_ack    <= !r_sel_d;
            r_state    <= StDone;
          end else begin
            r_idle <= r_idle + 32'd1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.i_ack   = r_i_ack;
  assign bus.d_ack   = r_d_ack;
  assign bus.i_rdata = r_rdata;
  assign bus.d_rdata = r_rdata;
  assign bus.i_fault = r_fault;
  assign bus.d_fault = r_fault;
  assign mem_cs      = r_mem_cs;
  assign mem_we      = r_mem_we;
  assign mem_size    = r_mem_size;
  assign mem_addr    = r_mem_addr;
  assign mem_dout    = r_mem_dout;
  assign gpo         = r_gpo;

endmodule
